// File: rtl/serial_pkg.sv
// serial_pkg: shared types and constants for the serial receive path.
package serial_pkg;
  localparam int BYTE_W = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 5207;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: show-ahead byte FIFO; a push while full succeeds only alongside a pop.
module byte_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] head,
  output logic              empty,
  output logic              full
);
  localparam int AW = $clog2(DEPTH);
  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = empty ? '0 : mem[rp];
  always_ff @(posedge sysclk)
    if (do_push) mem[wp] <= push_data;
  always_ff @(posedge sysclk)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/serial_rx.sv
// serial_rx: 8N1 receiver with byte FIFO, framing and overrun pulses.
// Define SERIAL_RX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              serial_in,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
`ifdef SERIAL_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_n;
  logic s1, rxs, push, fe_n, full, empty, pop, par_bad;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [BYTE_W-1:0] sh, sh_n;
  assign rx_valid = !empty;
  assign pop = rx_valid && rx_ready;
  assign busy = state != IDLE;
`ifdef SERIAL_RX_PARITY_EN
  logic par_bad_n;
  always_ff @(posedge sysclk)
    if (!reset) par_bad <= 1'b0;
    else par_bad <= par_bad_n;
`else
  assign par_bad = 1'b0;
`endif
  always_ff @(posedge sysclk)
    if (!reset) begin
      s1 <= 1'b1;
      rxs <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      s1 <= serial_in;
      rxs <= s1;
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      frame_err <= fe_n;
      overrun <= push && full && !pop;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt + CW'(1);
    idx_n = idx;
    sh_n = sh;
    push = 1'b0;
    fe_n = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_bad_n = par_bad;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxs) state_n = START;
      end
      START:
        if (cnt == MID) begin
          cnt_n = '0;
          idx_n = '0;
          state_n = rxs ? IDLE : DATA;
        end
      DATA:
        if (cnt == LAST) begin
          cnt_n = '0;
          sh_n[idx] = rxs;
          idx_n = idx + 3'd1;
          if (idx == 3'd7) state_n = AFTER_DATA;
        end
`ifdef SERIAL_RX_PARITY_EN
      PARITY:
        if (cnt == LAST) begin
          cnt_n = '0;
          par_bad_n = rxs ^ (^sh);
          state_n = STOP;
        end
`endif
      STOP:
        if (cnt == LAST) begin
          cnt_n = '0;
          push = rxs && !par_bad;
          fe_n = !rxs || par_bad;
          state_n = rxs ? IDLE : WAIT_IDLE;
        end
      WAIT_IDLE:
        if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .sysclk(sysclk),
    .reset(reset),
    .push(push),
    .push_data(sh),
    .pop(pop),
    .head(rx_data),
    .empty(empty),
    .full(full)
  );
endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: scoreboard bench for serial_rx at 16 clocks per bit.
module tb_serial_rx;
  localparam int CPB = 16;
  logic sysclk = 1'b0, reset = 1'b0, serial_in = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data, mon_exp;
  logic rx_valid, frame_err, overrun, busy;
  int errors = 0, checks = 0, fe_cnt = 0, ov_cnt = 0;
  logic [7:0] sbq[$];

  serial_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .sysclk(sysclk), .reset(reset), .serial_in(serial_in), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 sysclk = ~sysclk;

  always @(negedge sysclk) begin
    fe_cnt += int'(frame_err);
    ov_cnt += int'(overrun);
    if (reset && rx_valid && rx_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL pop: got %h, required no byte", rx_data);
      end else begin
        mon_exp = sbq.pop_front();
        if (rx_data !== mon_exp) begin
          errors++;
          $display("FAIL pop: got %h, required %h", rx_data, mon_exp);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge sysclk);
      #1 serial_in = bits[i];
      repeat (CPB - 1) @(posedge sysclk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    checks++;
    if ({rx_valid, rx_data, frame_err, overrun, busy} !== 12'h0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h fe=%b ov=%b busy=%b, required all 0",
               rx_valid, rx_data, frame_err, overrun, busy);
    end
    #1 reset = 1'b1;
    idle(5);
  endtask

  task automatic test_basic;
    int lat;
    lat = 0;
    rx_ready = 1'b0;
    sbq.push_back(8'h41);
    fork
      send_byte(8'h41, 1'b1);
      begin
        @(posedge sysclk);
        while (lat < 300) begin
          @(posedge sysclk);
          lat++;
          @(negedge sysclk);
          if (rx_valid) break;
        end
      end
    join
    checks++;
    if (!rx_valid || lat > 155) begin
      errors++;
      $display("FAIL latency: valid=%b after %0d cycles, required 1 within 155", rx_valid, lat);
    end
    checks++;
    if (rx_data !== 8'h41) begin
      errors++;
      $display("FAIL head: got %h, required 41", rx_data);
    end
    #1 rx_ready = 1'b1;
    @(posedge sysclk);
    #1 rx_ready = 1'b0;
    @(negedge sysclk);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL pop_clear: valid=%b, required 0", rx_valid);
    end
    idle(10);
  endtask

  task automatic test_glitch;
    int fe0;
    fe0 = fe_cnt;
    @(posedge sysclk);
    #1 serial_in = 1'b0;
    repeat (6) @(posedge sysclk);
    @(negedge sysclk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy: busy=%b, required 1", busy);
    end
    #1 serial_in = 1'b1;
    repeat (5) @(posedge sysclk);
    @(negedge sysclk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_idle: busy=%b, required 0", busy);
    end
    idle(20);
    checks++;
    if (fe_cnt != fe0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_flags: fe pulses=%0d valid=%b, required 0 and 0", fe_cnt - fe0, rx_valid);
    end
  endtask

  task automatic test_frame_err;
    int fe0;
    fe0 = fe_cnt;
    rx_ready = 1'b0;
    send_byte(8'h55, 1'b0);
    idle(40);
    serial_in = 1'b1;
    idle(30);
    checks++;
    if (fe_cnt - fe0 != 1) begin
      errors++;
      $display("FAIL frame_err_count: got %0d pulses, required 1", fe_cnt - fe0);
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_push: valid=%b, required 0", rx_valid);
    end
    rx_ready = 1'b1;
    sbq.push_back(8'h0A);
    send_byte(8'h0A, 1'b1);
    idle(20);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL after_break: %0d bytes outstanding, required 0", sbq.size());
    end
  endtask

  task automatic fill4;
    rx_ready = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      sbq.push_back(8'(b));
      send_byte(8'(b), 1'b1);
    end
  endtask

  task automatic drain_check(input string tag);
    rx_ready = 1'b1;
    idle(8);
    rx_ready = 1'b0;
    checks++;
    if (sbq.size() != 0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: outstanding=%0d valid=%b, required 0 and 0", tag, sbq.size(), rx_valid);
    end
  endtask

  task automatic test_overrun;
    int ov0;
    ov0 = ov_cnt;
    fill4();
    send_byte(8'h05, 1'b1);
    idle(20);
    checks++;
    if (ov_cnt - ov0 != 1) begin
      errors++;
      $display("FAIL overrun_count: got %0d pulses, required 1", ov_cnt - ov0);
    end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h01) begin
      errors++;
      $display("FAIL overrun_head: valid=%b data=%h, required 1 and 01", rx_valid, rx_data);
    end
    drain_check("overrun");
  endtask

  task automatic test_full_pop;
    int ov0;
    ov0 = ov_cnt;
    fill4();
    sbq.push_back(8'h7E);
    fork
      send_byte(8'h7E, 1'b1);
      begin
        repeat (155) @(posedge sysclk);
        #1 rx_ready = 1'b1;
        @(posedge sysclk);
        #1 rx_ready = 1'b0;
      end
    join
    idle(20);
    checks++;
    if (ov_cnt != ov0) begin
      errors++;
      $display("FAIL full_pop_overrun: got %0d pulses, required 0", ov_cnt - ov0);
    end
    checks++;
    if (sbq.size() != 4) begin
      errors++;
      $display("FAIL full_pop_count: outstanding=%0d, required 4", sbq.size());
    end
    drain_check("full_pop");
  endtask

  task automatic test_reset_mid;
    logic [9:0] bits;
    rx_ready = 1'b0;
    send_byte(8'h99, 1'b1);
    bits = {1'b1, 8'h33, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(posedge sysclk);
      #1 serial_in = bits[i];
      repeat (CPB - 1) @(posedge sysclk);
    end
    @(posedge sysclk);
    #1 serial_in = bits[3];
    repeat (8) @(posedge sysclk);
    @(negedge sysclk);
    checks++;
    if (rx_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: valid=%b busy=%b, required 1 and 1", rx_valid, busy);
    end
    #1 reset = 1'b0;
    serial_in = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    checks++;
    if ({rx_valid, rx_data, frame_err, overrun, busy} !== 12'h0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b data=%h fe=%b ov=%b busy=%b, required all 0",
               rx_valid, rx_data, frame_err, overrun, busy);
    end
    #1 reset = 1'b1;
    idle(20);
    rx_ready = 1'b1;
    sbq.push_back(8'hC3);
    send_byte(8'hC3, 1'b1);
    idle(20);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL after_reset: outstanding=%0d, required 0", sbq.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_full_pop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
